// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch, data-side read and programming-write bundle for imem_sync.
// The master drives addresses, enables and write data. The slave (the memory) returns
// registered read data, error flags, ready and perr.
interface imem_sync_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              ready;
  logic [31:0]       a;
  logic              f_en;
  logic [DATA_W-1:0] inst;
  logic              f_err;
  logic [31:0]       rom_a;
  logic              d_en;
  logic [DATA_W-1:0] d_f_rom;
  logic              d_err;
  logic              prog_we;
  logic [31:0]       prog_a;
  logic [DATA_W-1:0] prog_d;
  logic              prog_err;
  logic              perr;

  modport master (
    input  ready, inst, f_err, d_f_rom, d_err, prog_err, perr,
    output a, f_en, rom_a, d_en, prog_we, prog_a, prog_d
  );

  modport slave (
    input  a, f_en, rom_a, d_en, prog_we, prog_a, prog_d,
    output ready, inst, f_err, d_f_rom, d_err, prog_err, perr
  );
endinterface

// File: rtl/imem_sync.sv
// imem_sync: synchronous, loadable instruction memory.
// - Two registered read ports: fetch and data-side.
// - One programming write port.
// - A zero-fill sweep after reset, plus range and alignment error flags.
// Optional feature macro: IMEM_PARITY_EN adds one stored even-parity bit per word and a
// sticky perr flag. Without the macro, perr is tied to 0.
module imem_sync #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic          clock,
  input logic          resetn,
  imem_sync_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [MEM_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]   r_inst, r_d_f_rom;
  logic                r_f_err, r_d_err, r_prog_err;
  logic                w_run, w_clearing;
  logic                w_we;
  logic [ADDR_W-1:0]   w_widx;
  logic [MEM_W-1:0]    w_wdata;

  function automatic logic f_oor(input logic [31:0] addr);
    return |addr[31:ADDR_W+2];
  endfunction

  function automatic logic f_mis(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

  logic [ADDR_W-1:0] w_f_idx, w_d_idx, w_p_idx;
  logic              w_f_oor, w_d_oor, w_p_bad;
  logic [MEM_W-1:0]  w_f_word, w_d_word;

  assign w_f_idx  = bus.a[ADDR_W+1:2];
  assign w_d_idx  = bus.rom_a[ADDR_W+1:2];
  assign w_p_idx  = bus.prog_a[ADDR_W+1:2];
  assign w_f_oor  = f_oor(bus.a);
  assign w_d_oor  = f_oor(bus.rom_a);
  assign w_p_bad  = f_oor(bus.prog_a) | f_mis(bus.prog_a);
  assign w_f_word = r_mem[w_f_idx];
  assign w_d_word = r_mem[w_d_idx];

  // State register: reset forces RESET from any state, including mid-sweep.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= StReset;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReset: w_state_next = CLEAR_ON_RESET ? StClear : StRun;
      StClear: if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StReset;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_run      = (r_state == StRun);
    w_clearing = (r_state == StClear);
  end

  // Clear sweep counter; it stays at 0 outside CLEAR, so every sweep starts from word 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + 1'b1;
    else                 r_clr_cnt <= '0;
  end

  // Write mux: the sweep owns the write port during CLEAR; a program write needs RUN.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = r_clr_cnt;
    w_wdata = '0;
    if (w_clearing) begin
      w_we = 1'b1;
    end else if (w_run && bus.prog_we && !w_p_bad) begin
      w_we   = 1'b1;
      w_widx = w_p_idx;
`ifdef IMEM_PARITY_EN
      w_wdata = {^bus.prog_d, bus.prog_d};
`else
      w_wdata = bus.prog_d;
`endif
    end
  end

  // Storage array: not reset. Reads elsewhere see the pre-edge word, which makes them read-first.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  // Fetch port register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_inst  <= '0;
      r_f_err <= 1'b0;
    end else if (!w_run) begin
      r_inst  <= '0;
      r_f_err <= 1'b0;
    end else if (bus.f_en) begin
      r_inst  <= w_f_oor ? '0 : w_f_word[DATA_W-1:0];
      r_f_err <= w_f_oor | f_mis(bus.a);
    end
  end

  // Data-side port register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_d_f_rom <= '0;
      r_d_err   <= 1'b0;
    end else if (!w_run) begin
      r_d_f_rom <= '0;
      r_d_err   <= 1'b0;
    end else if (bus.d_en) begin
      r_d_f_rom <= w_d_oor ? '0 : w_d_word[DATA_W-1:0];
      r_d_err   <= w_d_oor | f_mis(bus.rom_a);
    end
  end

  // Dropped-write pulse. Writes outside RUN are dropped silently.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_prog_err <= 1'b0;
    else         r_prog_err <= w_run & bus.prog_we & w_p_bad;
  end

`ifdef IMEM_PARITY_EN
  logic r_perr;
  // Sticky parity flag: any enabled in-range read with odd stored parity sets it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_perr <= 1'b0;
    end else if (w_run && ((bus.f_en && !w_f_oor && (^w_f_word)) ||
                           (bus.d_en && !w_d_oor && (^w_d_word)))) begin
      r_perr <= 1'b1;
    end
  end
  assign bus.perr = r_perr;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.ready    = w_run;
  assign bus.inst     = r_inst;
  assign bus.f_err    = r_f_err;
  assign bus.d_f_rom  = r_d_f_rom;
  assign bus.d_err    = r_d_err;
  assign bus.prog_err = r_prog_err;
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed and randomized checks of imem_sync against a word-array model.
module tb_imem_sync;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 128;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  imem_sync_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_sync #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mm [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_oor(input logic [31:0] addr);
    return addr >= DEPTH * 4;
  endfunction

  function automatic bit m_mis(input logic [31:0] addr);
    return (addr % 4) != 0;
  endfunction

  function automatic int m_idx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] gen_addr();
    case ($urandom_range(0, 5))
      0:       return $urandom | 32'h0000_0200;
      1:       return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      2:       return 32'($urandom_range(0, 127) * 4);
      default: return 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.a = '0; bus.f_en = 1'b0; bus.rom_a = '0; bus.d_en = 1'b0;
    bus.prog_we = 1'b0; bus.prog_a = '0; bus.prog_d = '0;
  endtask

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    bus.prog_we = 1'b1; bus.prog_a = addr; bus.prog_d = data;
    step();
    bus.prog_we = 1'b0;
    if (!m_oor(addr) && !m_mis(addr)) mm[m_idx(addr)] = data;
  endtask

  // Counts edges after reset release until ready. Meanwhile it keeps enables and a
  // program write active, and tallies any visible effect they have.
  task automatic wait_ready(output int cyc, output int leaks);
    cyc   = 0;
    leaks = 0;
    bus.f_en = 1'b1; bus.a = 32'h4; bus.d_en = 1'b1; bus.rom_a = 32'h8;
    bus.prog_we = 1'b1; bus.prog_a = 32'h0; bus.prog_d = 32'hFFFF_FFFF;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock);
      #1;
      if (bus.ready === 1'b1) begin
        cyc = i;
        break;
      end
      if (bus.inst !== '0 || bus.f_err !== 1'b0 || bus.d_f_rom !== '0 ||
          bus.d_err !== 1'b0 || bus.prog_err !== 1'b0) leaks++;
    end
    idle();
    for (int k = 0; k < DEPTH; k++) mm[k] = '0;
  endtask

  initial begin
    int          cyc, leaks;
    logic [31:0] e_inst, e_d;
    logic        e_ferr, e_derr, e_perr;

    idle();
    #12;
    // Reset state.
    check("rst_ready", bus.ready, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_f_err", bus.f_err, 0);
    check("rst_d_f_rom", bus.d_f_rom, 0);
    check("rst_d_err", bus.d_err, 0);
    check("rst_prog_err", bus.prog_err, 0);
    check("rst_perr", bus.perr, 0);

    // Release reset. Edge 1 enters CLEAR, and 128 sweep edges follow, so ready shows after edge 129.
    step();
    resetn = 1'b1;
    wait_ready(cyc, leaks);
    check("clear_ready_cycle", cyc, 129);
    check("clear_port_leaks", leaks, 0);
    bus.a = 32'h1FC; bus.f_en = 1'b1;
    step();
    check("clear_1fc_inst", bus.inst, 0);
    check("clear_1fc_f_err", bus.f_err, 0);
    bus.a = 32'h0; bus.rom_a = 32'h0; bus.d_en = 1'b1;
    step();
    check("clear_dropped_write", bus.inst, 0);
    idle();

    // Load and fetch, then stall.
    prog(32'h8, 32'h2001_0005);
    bus.a = 32'h8; bus.f_en = 1'b1;
    step();
    check("fetch_inst", bus.inst, 32'h2001_0005);
    check("fetch_f_err", bus.f_err, 0);
    prog(32'hC, 32'h1111_2222);
    bus.f_en = 1'b0; bus.a = 32'hC;
    step();
    step();
    check("stall_hold", bus.inst, 32'h2001_0005);

    // Error cases.
    prog(32'h4, 32'hCAFE_0001);
    bus.a = 32'h200; bus.f_en = 1'b1; bus.rom_a = 32'h6; bus.d_en = 1'b1;
    step();
    check("oor_inst", bus.inst, 0);
    check("oor_f_err", bus.f_err, 1);
    check("mis_d_f_rom", bus.d_f_rom, 32'hCAFE_0001);
    check("mis_d_err", bus.d_err, 1);
    idle();
    bus.prog_we = 1'b1; bus.prog_a = 32'h400; bus.prog_d = 32'hDEAD_BEEF;
    step();
    check("bad_write_pulse", bus.prog_err, 1);
    idle();
    bus.a = 32'h0; bus.f_en = 1'b1;
    step();
    check("bad_write_pulse_end", bus.prog_err, 0);
    check("bad_write_no_alias", bus.inst, 0);
    idle();

    // Collision: read-first on both ports.
    prog(32'h10, 32'h1234_5678);
    bus.prog_we = 1'b1; bus.prog_a = 32'h10; bus.prog_d = 32'hAAAA_5555;
    bus.a = 32'h10; bus.f_en = 1'b1; bus.rom_a = 32'h10; bus.d_en = 1'b1;
    step();
    mm[4] = 32'hAAAA_5555;
    bus.prog_we = 1'b0;
    check("coll_old_inst", bus.inst, 32'h1234_5678);
    check("coll_old_d", bus.d_f_rom, 32'h1234_5678);
    step();
    check("coll_new_inst", bus.inst, 32'hAAAA_5555);
    check("coll_new_d", bus.d_f_rom, 32'hAAAA_5555);
    idle();

    // Randomized traffic against the array model.
    e_inst = bus.inst; e_ferr = bus.f_err; e_d = bus.d_f_rom; e_derr = bus.d_err;
    for (int n = 0; n < 300; n++) begin
      bus.a = gen_addr(); bus.rom_a = gen_addr(); bus.prog_a = gen_addr();
      bus.f_en = 1'($urandom); bus.d_en = 1'($urandom); bus.prog_we = 1'($urandom);
      bus.prog_d = $urandom;
      step();
      if (bus.f_en) begin
        e_inst = m_oor(bus.a) ? '0 : mm[m_idx(bus.a)];
        e_ferr = m_oor(bus.a) || m_mis(bus.a);
      end
      if (bus.d_en) begin
        e_d    = m_oor(bus.rom_a) ? '0 : mm[m_idx(bus.rom_a)];
        e_derr = m_oor(bus.rom_a) || m_mis(bus.rom_a);
      end
      check("rnd_inst", bus.inst, e_inst);
      check("rnd_f_err", bus.f_err, e_ferr);
      check("rnd_d_f_rom", bus.d_f_rom, e_d);
      check("rnd_d_err", bus.d_err, e_derr);
      check("rnd_prog_err", bus.prog_err,
            bus.prog_we && (m_oor(bus.prog_a) || m_mis(bus.prog_a)));
      check("rnd_perr", bus.perr, 0);
      if (bus.prog_we && !m_oor(bus.prog_a) && !m_mis(bus.prog_a))
        mm[m_idx(bus.prog_a)] = bus.prog_d;
    end
    idle();

    // Reset in the middle of the sweep. The second sweep must be full length and zero all words.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 41; i++) step();
    check("midclear_not_ready", bus.ready, 0);
    resetn = 1'b0;
    step();
    check("midclear_rst_ready", bus.ready, 0);
    resetn = 1'b1;
    wait_ready(cyc, leaks);
    check("midclear_ready_cycle", cyc, 129);
    check("midclear_port_leaks", leaks, 0);
    for (int w = 0; w < DEPTH; w++) begin
      bus.a = 32'(w * 4); bus.rom_a = 32'((DEPTH - 1 - w) * 4);
      bus.f_en = 1'b1; bus.d_en = 1'b1;
      step();
      check("zero_inst", bus.inst, mm[w]);
      check("zero_d", bus.d_f_rom, mm[DEPTH - 1 - w]);
    end
    idle();

`ifdef IMEM_PARITY_EN
    prog(32'hC, 32'h0000_0005);
    dut.r_mem[3][0] = ~dut.r_mem[3][0];
    bus.a = 32'hC; bus.f_en = 1'b1;
    step();
    idle();
    check("parity_set", bus.perr, 1);
    step();
    check("parity_sticky", bus.perr, 1);
    resetn = 1'b0;
    step();
    check("parity_reset", bus.perr, 0);
    resetn = 1'b1;
`else
    bus.a = 32'hC; bus.f_en = 1'b1;
    step();
    idle();
    check("parity_off", bus.perr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous, loadable instruction memory for the MIPS SoC. It replaces the fixed 128-word combinational ROM.
- Two independent registered read ports: instruction fetch and data-side constant reads.
- One programming write port, so software can be reloaded without resynthesis.
- A post-reset clear sweep, and address/alignment error flags on every port.

## Interface
- ADDR_W, 7: word-address width; depth = 2**ADDR_W words.
- DATA_W, 32: word width in bits.
- CLEAR_ON_RESET, 1: 1 = run the zero-fill sweep after reset; 0 = go straight to RUN with contents undefined.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- ready  out  1  1 when in RUN state
- a  in  32  fetch byte address
- f_en  in  1  fetch enable; 0 = stall, inst holds
- inst  out  DATA_W  registered fetch data
- f_err  out  1  registered fetch error
- rom_a  in  32  data-port byte address
- d_en  in  1  data-port read enable
- d_f_rom  out  DATA_W  registered data-port data
- d_err  out  1  registered data-port error
- prog_we  in  1  program write strobe
- prog_a  in  32  program byte address
- prog_d  in  DATA_W  program write data
- prog_err  out  1  one-cycle pulse: write dropped
- perr  out  1  sticky parity error (see Configuration)

## Operation
- Word index is addr[ADDR_W+1:2].
- Out of range: any of addr[31:ADDR_W+2] nonzero.
- Misaligned: addr[1:0] != 0.
- FSM states: RESET, CLEAR, RUN.
  - RESET: held while resetn=0.
  - RESET -> CLEAR when resetn deasserts and CLEAR_ON_RESET=1; RESET -> RUN when CLEAR_ON_RESET=0.
  - CLEAR: a counter writes 0 to words 0..2**ADDR_W-1, one word per cycle. On the final word it goes to RUN.
  - resetn low in any state, including mid-CLEAR: immediately to RESET. The counter restarts from 0 on the next CLEAR.
- RUN, read port (each port independent, identical rules):
  - When enable=1, the port registers mem[index] into its data output and updates its err output.
  - Out of range: data <= 0, err <= 1.
  - Misaligned but in range: data <= mem[index], err <= 1.
  - Otherwise: data <= mem[index], err <= 0.
  - When enable=0, data and err hold their values.
- RUN, write port:
  - prog_we=1 with an in-range, aligned address writes prog_d to mem[index].
  - Out-of-range or misaligned: write dropped, prog_err=1 on the next cycle.
- Read-during-write to the same index in the same cycle is read-first: the read returns the old word, and the new word is visible from the next read.
- Both read ports may address the same word in the same cycle; both return it.
- In RESET and CLEAR:
  - f_en and d_en are ignored; inst, d_f_rom, f_err, d_err hold 0.
  - prog_we is dropped without prog_err.

## Timing
- Reset values: ready=0, inst=0, f_err=0, d_f_rom=0, d_err=0, prog_err=0, perr=0, clear counter=0.
- Read latency is 1 cycle: address and enable sampled at edge N, data valid after edge N, usable in cycle N+1.
- Write takes effect at the edge where prog_we is sampled.
- ready rises on the edge after the last clear write, 2**ADDR_W cycles after the first CLEAR cycle (128 for the defaults). With CLEAR_ON_RESET=0, ready rises on the first edge after resetn deasserts.
- prog_err is a single-cycle pulse per dropped write; back-to-back bad writes give a continuous high level.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores DATA_W+1 bits: data plus one even-parity bit, computed on program writes and on clear writes (parity 0).
  - Every enabled in-range read recomputes parity; on a mismatch perr sets on the same edge the data is registered.
  - perr stays set until resetn is asserted.
  - Output data is not corrected.
- IMEM_PARITY_EN undefined: no parity storage or checker; perr is tied to 0.

## Test plan
- Reset then clear: release resetn, CLEAR_ON_RESET=1, ADDR_W=7 -> ready=0 for 128 cycles then 1; a read of a=0x1FC returns 0 with f_err=0.
- Load and fetch: write 0x2001_0005 to prog_a=0x8, then f_en=1, a=0x8 -> inst=0x2001_0005 one cycle later. With f_en=0 and a changed to 0xC, inst holds.
- Error cases:
  - a=0x200 -> inst=0, f_err=1.
  - rom_a=0x6 -> d_err=1, d_f_rom=mem[1].
  - prog_a=0x400 with prog_we=1 -> prog_err pulse; no word changes.
- Collision: prog_we to 0x10 (new 0xAAAA_5555) while a=0x10 and rom_a=0x10 with old value 0x1234_5678 -> both ports return 0x1234_5678; the next reads return 0xAAAA_5555.
- Reset mid-CLEAR: assert resetn at clear index 40, then release -> ready stays 0 for a full 128 cycles and every word reads 0.
- Parity (macro on): force-flip one stored data bit at word 3 and read a=0xC -> perr=1 after the edge and stays 1; after reset perr=0. With the macro off, perr stays 0.
